// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core front end.
//   XLEN          : data / address width
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0), shown in the empty output slot
//   fetch_state_t : fetch FSM states
//     RUN     - no memory request outstanding
//     WAIT    - request outstanding, its result will be presented
//     DISCARD - request outstanding, its result will be dropped (redirected)
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the program counter, fetches words from
// instruction memory over a req/ack handshake and presents them downstream
// with a valid/ready handshake. A branch redirect flushes the presented
// instruction, drops any in-flight fetch result and restarts at the target.
//
// Ports:
//   clk                       in   rising-edge clock
//   reset_n                   in   asynchronous active-low reset
//   enable_n                  in   low = new fetches may start
//   mem_req / mem_addr        out  fetch request and word-aligned address
//   mem_ack / mem_rdata       in   response strobe and instruction word
//   load_new_program_counter  in   redirect strobe (only a clean 1 counts)
//   new_program_counter       in   redirect target, bits [1:0] ignored
//   instruction               out  presented instruction
//   program_counter           out  address of the presented instruction
//   instruction_valid         out  output slot full
//   instruction_ready         in   consumer takes the slot when valid & ready
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable_n,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            load_new_program_counter,
  input  logic [XLEN-1:0] new_program_counter,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] program_counter,
  output logic            instruction_valid,
  input  logic            instruction_ready
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            live_q;

  logic            redirect;
  logic            slot_free;
  logic            capture;
  logic [XLEN-1:0] redirect_pc;
  logic [1:0]      unused_npc_bits;

  // A floating or unknown strobe must never redirect, hence the 4-state compare.
  assign redirect        = (load_new_program_counter === 1'b1);
  assign redirect_pc     = {new_program_counter[XLEN-1:2], 2'b00};
  assign unused_npc_bits = new_program_counter[1:0];
  assign slot_free       = !valid_q || instruction_ready;

  // live_q keeps the request low while reset is held and for the release
  // cycle, so no request is ever seen straddling reset deassertion.
  always_comb begin
    mem_req = 1'b0;
    if (live_q) begin
      if (state_q == RUN) mem_req = !enable_n && slot_free && !redirect;
      else                mem_req = 1'b1;
    end
  end

  assign mem_addr          = fetch_pc_q;
  assign instruction       = instr_q;
  assign program_counter   = pc_q;
  assign instruction_valid = valid_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    capture    = 1'b0;

    if (valid_q && instruction_ready) valid_d = 1'b0;

    case (state_q)
      RUN: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          valid_d    = 1'b0;
        end else if (mem_req) begin
          if (mem_ack) capture = 1'b1;
          else         state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          valid_d = 1'b0;
          if (mem_ack) begin
            fetch_pc_d = redirect_pc;
            state_d    = RUN;
          end else begin
            // The old address must stay on the bus until its ack, so the
            // target is parked until then.
            target_d = redirect_pc;
            state_d  = DISCARD;
          end
        end else if (mem_ack) begin
          capture = 1'b1;
        end
      end
      DISCARD: begin
        if (redirect) target_d = redirect_pc;
        if (mem_ack) begin
          fetch_pc_d = target_d;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (capture) begin
      instr_d    = mem_rdata;
      pc_d       = fetch_pc_q;
      valid_d    = 1'b1;
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      state_d    = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      live_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-programmable memory responder, a monitor
// that pops expected {pc, instruction} pairs on every valid & ready transfer,
// and one task per scenario.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata;
  logic        load;
  logic [31:0] npc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        ready;

  int errors = 0;
  int checks = 0;
  int lat    = 0;
  int wcnt   = 0;
  logic force_ack = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign mem_rdata = memword(mem_addr);

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .enable_n                 (enable_n),
    .mem_req                  (mem_req),
    .mem_addr                 (mem_addr),
    .mem_ack                  (mem_ack),
    .mem_rdata                (mem_rdata),
    .load_new_program_counter (load),
    .new_program_counter      (npc),
    .instruction              (instr),
    .program_counter          (pc),
    .instruction_valid        (valid),
    .instruction_ready        (ready)
  );

  // Memory: ack arrives `lat` cycles after the request first appears.
  always begin
    @(negedge clk);
    #1;
    if (mem_req) begin
      mem_ack = force_ack || (wcnt >= lat);
      if (mem_ack) wcnt = 0;
      else         wcnt = wcnt + 1;
    end else begin
      mem_ack = force_ack;
      wcnt    = 0;
    end
  end

  // Scoreboard consumer: every transfer must match the oldest expectation.
  always begin
    @(negedge clk);
    #4;
    if (valid === 1'b1 && ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: presented pc=%h instr=%h, required nothing", pc, instr);
      end else begin
        exp_e = exp_q.pop_front();
        if ({pc, instr} !== exp_e) begin
          errors++;
          $display("FAIL sb_xfer: got pc=%h instr=%h, required pc=%h instr=%h",
                   pc, instr, exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] a);
    exp_q.push_back({a, memword(a)});
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable_n = 1'b1; ready = 1'b0; load = 1'b0; npc = '0; lat = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b, required 0", mem_req); end
    checks++; if (mem_addr !== RST_PC) begin errors++; $display("FAIL rst_addr: got %h, required %h", mem_addr, RST_PC); end
    checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr: got %h, required 00000013", instr); end
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL rst_pc: got %h, required %h", pc, RST_PC); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", valid); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL disabled_req: got %b, required 0", mem_req); end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 8; i++) push_exp(RST_PC + 32'(4 * i));
    @(negedge clk);
    enable_n = 1'b0; ready = 1'b1; lat = 0;
    for (int i = 0; i < 8; i++) begin
      #4;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== RST_PC + 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_addr: got req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, RST_PC + 32'(4 * i));
      end
      @(negedge clk);
    end
    enable_n = 1'b1;
    #4;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL seq_stop: got req=%b, required 0", mem_req); end
    repeat (3) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL seq_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_backpressure;
    push_exp(32'h120);
    @(negedge clk);
    lat = 3; ready = 1'b0; enable_n = 1'b0;
    repeat (6) @(negedge clk);
    #4;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b, required 0", mem_req); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", valid); end
    checks++; if (pc !== 32'h120 || instr !== memword(32'h120)) begin errors++; $display("FAIL bp_data: got pc=%h instr=%h, required pc=00000120 instr=%h", pc, instr, memword(32'h120)); end
    checks++; if (mem_addr !== 32'h124) begin errors++; $display("FAIL bp_addr: got %h, required 00000124", mem_addr); end
    @(negedge clk);
    #4;
    checks++; if (pc !== 32'h120 || instr !== memword(32'h120)) begin errors++; $display("FAIL bp_stable: got pc=%h instr=%h, required pc=00000120", pc, instr); end
    @(negedge clk);
    ready = 1'b1;
    push_exp(32'h124);
    #4;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h124) begin errors++; $display("FAIL bp_restart: got req=%b addr=%h, required req=1 addr=00000124", mem_req, mem_addr); end
    @(negedge clk);
    enable_n = 1'b1;
    #4;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h124) begin errors++; $display("FAIL wait_hold: got req=%b addr=%h, required req=1 addr=00000124", mem_req, mem_addr); end
    repeat (6) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_redirect_wait;
    @(negedge clk);
    load = 1'b1; npc = 32'h40; enable_n = 1'b1;
    @(negedge clk);
    load = 1'b0; enable_n = 1'b0; lat = 3;
    push_exp(32'h2000);
    #4;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL rw_start: got req=%b addr=%h, required req=1 addr=00000040", mem_req, mem_addr); end
    @(negedge clk);
    load = 1'b1; npc = 32'h2003; enable_n = 1'b1;
    #4;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL rw_redir: got req=%b addr=%h, required req=1 addr=00000040", mem_req, mem_addr); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      load = 1'b0; enable_n = 1'b0;
      #4;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL discard_hold: got req=%b addr=%h, required req=1 addr=00000040", mem_req, mem_addr); end
    end
    @(negedge clk);
    #4;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin errors++; $display("FAIL rw_target: got req=%b addr=%h, required req=1 addr=00002000", mem_req, mem_addr); end
    @(negedge clk);
    enable_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rw_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_redirect_consume;
    @(negedge clk);
    lat = 0; enable_n = 1'b0; ready = 1'b1;
    push_exp(32'h2004);
    #4;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2004) begin errors++; $display("FAIL rc_first: got req=%b addr=%h, required req=1 addr=00002004", mem_req, mem_addr); end
    @(negedge clk);
    load = 1'b1; npc = 32'h3000;
    #4;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rc_req_low: got %b, required 0", mem_req); end
    @(negedge clk);
    load = 1'b0;
    push_exp(32'h3000);
    #4;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rc_flush: got valid=%b, required 0", valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin errors++; $display("FAIL rc_target: got req=%b addr=%h, required req=1 addr=00003000", mem_req, mem_addr); end
    @(negedge clk);
    enable_n = 1'b1;
    @(negedge clk);
    lat = 1; enable_n = 1'b0;
    #4;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3004) begin errors++; $display("FAIL ra_start: got req=%b addr=%h, required req=1 addr=00003004", mem_req, mem_addr); end
    @(negedge clk);
    load = 1'b1; npc = 32'h5000; enable_n = 1'b1;
    #4;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ra_hold: got req=%b, required 1", mem_req); end
    @(negedge clk);
    load = 1'b0; enable_n = 1'b0;
    push_exp(32'h5000);
    #4;
    checks++; if (valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h5000) begin errors++; $display("FAIL ra_drop: got valid=%b req=%b addr=%h, required valid=0 req=1 addr=00005000", valid, mem_req, mem_addr); end
    @(negedge clk);
    enable_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rc_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_xz_ignored;
    for (int i = 0; i < 4; i++) push_exp(32'h5004 + 32'(4 * i));
    @(negedge clk);
    lat = 0; enable_n = 1'b0; ready = 1'b1; load = 1'bz; npc = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      #4;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h5004 + 32'(4 * i)) begin
        errors++;
        $display("FAIL xz_seq: got req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, 32'h5004 + 32'(4 * i));
      end
      @(negedge clk);
    end
    enable_n = 1'b1; load = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL xz_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_wrap;
    logic [31:0] a;
    @(negedge clk);
    load = 1'b1; npc = 32'hFFFF_FFF8; enable_n = 1'b1;
    @(negedge clk);
    load = 1'b0; enable_n = 1'b0; lat = 0;
    for (int i = 0; i < 4; i++) begin
      a = 32'hFFFF_FFF8 + 32'(4 * i);
      push_exp(a);
    end
    for (int i = 0; i < 4; i++) begin
      a = 32'hFFFF_FFF8 + 32'(4 * i);
      #4;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== a) begin
        errors++;
        $display("FAIL wrap_addr: got req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, a);
      end
      @(negedge clk);
    end
    enable_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk);
    lat = 5; enable_n = 1'b0; ready = 1'b1;
    #4;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin errors++; $display("FAIL rstw_start: got req=%b addr=%h, required req=1 addr=00000008", mem_req, mem_addr); end
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0; enable_n = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstw_req: got %b, required 0", mem_req); end
    checks++; if (mem_addr !== RST_PC) begin errors++; $display("FAIL rstw_addr: got %h, required %h", mem_addr, RST_PC); end
    checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL rstw_instr: got %h, required 00000013", instr); end
    checks++; if (pc !== RST_PC || valid !== 1'b0) begin errors++; $display("FAIL rstw_pc: got pc=%h valid=%b, required pc=%h valid=0", pc, valid, RST_PC); end
    @(negedge clk);
    reset_n = 1'b1; force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    #4;
    checks++; if (valid !== 1'b0 || pc !== RST_PC || mem_addr !== RST_PC) begin errors++; $display("FAIL late_ack: got valid=%b pc=%h addr=%h, required valid=0 pc=%h addr=%h", valid, pc, mem_addr, RST_PC, RST_PC); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstw_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_sequential;
    test_backpressure;
    test_redirect_wait;
    test_redirect_consume;
    test_xz_ignored;
    test_wrap;
    test_reset_in_wait;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
